sipo_deser: RTL and testbench
=============================

# sipo_deser

Parametrised multi-lane serial-to-parallel deserialiser. It accumulates `LANES` bits per accepted beat into a `DATA_WIDTH`-bit word, with runtime shift direction and output bit order. Each completed word is delivered through a one-entry valid/ready output slot, and a sticky overflow flag records words dropped under backpressure. It sits between serial front-end capture and word-level consumers, replacing the single-bit SIPO register.

## Interface
- `DATA_WIDTH`, default 32: word width. Must be a multiple of `LANES`; elaboration-time check.
- `LANES`, default 1: bits per beat, 1..`DATA_WIDTH`. `BEATS = DATA_WIDTH/LANES`.

- `clk`, input, 1: clock.
- `arst_n`, input, 1: reset, asynchronous, active-low.
- `serial_in`, input, `LANES`: beat data. Lane 0 is the newest bit in shift-left mode.
- `in_valid`, input, 1: beat accepted this cycle. There is no input backpressure.
- `shift_dir`, input, 1: 1 = shift left, 0 = shift right. Sampled on the first beat of a word.
- `out_dir`, input, 1: 1 = bit-reverse the word on delivery. Sampled on the first beat of a word.
- `flush`, input, 1: synchronous discard of the partial word.
- `out_data`, output, `DATA_WIDTH`: delivered word.
- `out_valid`, output, 1: output slot full.
- `out_ready`, input, 1: consumer accepts `out_data` when `out_valid && out_ready`.
- `out_perr`, output, 1: parity error for `out_data`. Tied 0 without parity.
- `overflow`, output, 1: sticky; a completed word was dropped.
- `ovf_clr`, input, 1: clears `overflow`.
- `busy`, output, 1: partial word in progress (beat count ≠ 0).

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on `in_valid`. This first beat counts as beat 1, and `shift_dir`/`out_dir` are latched here.
  - SHIFT → IDLE on acceptance of beat `BEATS`.
  - With parity enabled, SHIFT → PARITY on beat `BEATS` instead, and PARITY → IDLE on the next accepted beat.
- Shift left: `acc <= {acc[DATA_WIDTH-LANES-1:0], serial_in}`.
- Shift right: `acc <= {serial_in, acc[DATA_WIDTH-1:LANES]}`.
- `LANES == DATA_WIDTH`: the beat loads `acc` directly; every beat completes a word.
- Word completion: the final assembled value, including the final beat, is bit-reversed if latched `out_dir` = 1, then written to the output slot.
- Slot free, or freed by a handshake in the same cycle: the word loads and `out_valid` = 1.
- Slot full and no handshake that cycle:
  - the new word is dropped and `overflow` is set;
  - the slot contents are unchanged.
- `ovf_clr` and a new overflow in the same cycle: set wins.
- `flush`:
  - the beat count returns to 0, the FSM goes to IDLE and `acc` clears;
  - a coincident `in_valid` beat is discarded;
  - the output slot is unaffected.
- Changes to `shift_dir`/`out_dir` mid-word are ignored until the next word starts.

## Timing
- Reset values: `out_data` = 0, `out_valid` = 0, `out_perr` = 0, `overflow` = 0, `busy` = 0, `acc` = 0, FSM = IDLE, count = 0.
- Latency: `out_valid` rises the cycle after the clock edge that accepts the final beat (or the parity beat).
- `out_valid` falls the cycle after a handshake, unless a new word loads on that same edge.
- Back-to-back streaming is sustained: a new word starts on the beat immediately after the last beat, with no gap cycle.
- Reset mid-word: all state returns to reset values immediately; the partial word is lost.

## Configuration
- Macro `SIPO_DESER_PARITY_EN`.
- Defined:
  - one extra parity beat follows each word; only `serial_in[0]` is used, other lanes are ignored;
  - even parity over the `DATA_WIDTH` data bits (pre-reversal);
  - `out_perr` = 1 if the XOR of data bits and the parity bit is 1;
  - the word is delivered after the parity beat;
  - `flush` during PARITY discards the word.
- Undefined: no PARITY state and `out_perr` is constant 0. The port is always present.

## Structure
- Package `sipo_pkg`:
  - `sipo_state_e` enum (IDLE, SHIFT, PARITY);
  - `bit_reverse` function, parametrised via the caller width;
  - the `BEATS` derivation.
- Sub-module `sipo_out_slot`: one-entry valid/ready holding register with load, drop detect and sticky `overflow`/`ovf_clr`.
- The top level holds the accumulator, beat counter and FSM.

## Test plan
All scenarios use `DATA_WIDTH`=8, `LANES`=2.
- Shift left, `out_dir`=0, beats 2'b10, 2'b11, 2'b00, 2'b01 with `out_ready`=1 → `out_data`=8'hB1, `out_valid` high 1 cycle after beat 4.
- Same beats with shift right → 8'h4E; with shift left and `out_dir`=1 → 8'h8D.
- `out_ready`=0, two complete words (8'hB1, then 8'h4E) → `out_data` stays 8'hB1 and `overflow`=1. Then `ovf_clr` with `out_ready`=1 → `overflow` 0, 8'hB1 consumed.
- `flush` after 2 beats, then 4 fresh beats → only the fresh word is delivered; `busy` drops the cycle after `flush`.
- Handshake on the same edge as the next word completes → no overflow, next word visible next cycle, `out_valid` stays 1.
- Parity build: 8'hB1 followed by parity bit 0 → `out_perr`=0; with parity bit 1 → `out_perr`=1. `arst_n` low mid-word → all outputs 0.

Source files
------------

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_pkg
// Description : Shared types and helpers for the sipo_deser deserialiser.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sipo_state_e;

    // Widest word bit_reverse can handle; callers pass their real width.
    localparam int unsigned SIPO_MAX_W = 1024;

    function automatic int unsigned sipo_beats(input int unsigned dw, input int unsigned lanes);
        return dw / lanes;
    endfunction

    // Reverses the low w bits of v; bits above w come back as zero.
    function automatic logic [SIPO_MAX_W-1:0] bit_reverse(input logic [SIPO_MAX_W-1:0] v,
                                                          input int unsigned w);
        logic [SIPO_MAX_W-1:0] r;
        for (int i = 0; i < SIPO_MAX_W; i++) begin
            r[i] = v[SIPO_MAX_W-1-i];
        end
        return r >> (SIPO_MAX_W - w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_out_slot.sv
`default_nettype none
// ============================================================================
// Module      : sipo_out_slot
// Description : One-entry valid/ready output register with sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_out_slot #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  perr_i,
    input  logic                  ready_i,
    input  logic                  ovf_clr_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  perr_o,
    output logic                  overflow_o
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ovf_q, ovf_d;
    logic                  w_hs;
    logic                  w_drop;

    assign w_hs = valid_q & ready_i;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        w_drop  = 1'b0;
        if (load_i) begin
            if (!valid_q || w_hs) begin
                data_d  = data_i;
                perr_d  = perr_i;
                valid_d = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end else if (w_hs) begin
            valid_d = 1'b0;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = w_drop ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign perr_o     = perr_q;
    assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deser
// Description : Multi-lane serial-to-parallel deserialiser with valid/ready
//               output slot. Define SIPO_DESER_PARITY_EN for a parity beat.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANES      = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [LANES-1:0]      serial_in,
    input  logic                  in_valid,
    input  logic                  shift_dir,
    input  logic                  out_dir,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_perr,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  busy
);

    localparam int unsigned   BEATS    = sipo_beats(DATA_WIDTH, LANES);
    localparam int unsigned   CW       = $clog2(BEATS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
    localparam logic [1:0]    ST_IDLE  = IDLE;
    localparam logic [1:0]    ST_SHIFT = SHIFT;
`ifdef SIPO_DESER_PARITY_EN
    localparam logic [1:0]    ST_PARITY = PARITY;
    localparam logic [CW-1:0] FULL_CNT  = CW'(BEATS);
`endif

    generate
        if ((LANES < 1) || (LANES > DATA_WIDTH) || ((DATA_WIDTH % LANES) != 0)
            || (DATA_WIDTH > SIPO_MAX_W)) begin : g_bad_cfg
            $error("sipo_deser: DATA_WIDTH must be a multiple of LANES (1..DATA_WIDTH)");
        end
    endgenerate

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  sdir_q, sdir_d;
    logic                  odir_q, odir_d;

    logic [DATA_WIDTH-1:0] w_shl, w_shr, w_shifted, w_src, w_word;
    logic                  w_first, w_sdir, w_odir, w_load, w_perr;

    generate
        if (LANES == DATA_WIDTH) begin : g_full
            assign w_shl = serial_in;
            assign w_shr = serial_in;
        end else begin : g_part
            assign w_shl = {acc_q[DATA_WIDTH-LANES-1:0], serial_in};
            assign w_shr = {serial_in, acc_q[DATA_WIDTH-1:LANES]};
        end
    endgenerate

    // Direction controls are live only on the first beat of a word.
    assign w_first   = (state_q == ST_IDLE);
    assign w_sdir    = w_first ? shift_dir : sdir_q;
    assign w_odir    = w_first ? out_dir : odir_q;
    assign w_shifted = w_sdir ? w_shl : w_shr;

`ifdef SIPO_DESER_PARITY_EN
    assign w_src  = (state_q == ST_PARITY) ? acc_q : w_shifted;
    assign w_perr = (^acc_q) ^ serial_in[0];
`else
    assign w_src  = w_shifted;
    assign w_perr = 1'b0;
`endif
    assign w_word = w_odir ? DATA_WIDTH'(bit_reverse(SIPO_MAX_W'(w_src), DATA_WIDTH)) : w_src;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sdir_d  = sdir_q;
        odir_d  = odir_q;
        w_load  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (in_valid) begin
            case (state_q)
                ST_IDLE, ST_SHIFT: begin
                    acc_d  = w_shifted;
                    sdir_d = w_sdir;
                    odir_d = w_odir;
                    if (cnt_q == LAST_CNT) begin
`ifdef SIPO_DESER_PARITY_EN
                        state_d = ST_PARITY;
                        cnt_d   = FULL_CNT;
`else
                        w_load  = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ST_SHIFT;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
`ifdef SIPO_DESER_PARITY_EN
                ST_PARITY: begin
                    w_load  = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sdir_q  <= 1'b0;
            odir_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sdir_q  <= sdir_d;
            odir_q  <= odir_d;
        end
    end

    assign busy = (cnt_q != '0);

    sipo_out_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
        .clk        (clk),
        .arst_n     (arst_n),
        .load_i     (w_load),
        .data_i     (w_word),
        .perr_i     (w_perr),
        .ready_i    (out_ready),
        .ovf_clr_i  (ovf_clr),
        .data_o     (out_data),
        .valid_o    (out_valid),
        .perr_o     (out_perr),
        .overflow_o (overflow)
    );

endmodule
`default_nettype wire

// File: tb/tb_sipo_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deser
// Description : Self-checking bench for sipo_deser (DATA_WIDTH=8, LANES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deser;

    localparam int DW = 8;
    localparam int LN = 2;
    localparam int NB = DW / LN;
`ifdef SIPO_DESER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [LN-1:0] serial_in;
    logic          in_valid, shift_dir, out_dir, flush, out_ready, ovf_clr;
    logic [DW-1:0] out_data;
    logic          out_valid, out_perr, overflow, busy;

    sipo_deser #(.DATA_WIDTH(DW), .LANES(LN)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .serial_in (serial_in),
        .in_valid  (in_valid),
        .shift_dir (shift_dir),
        .out_dir   (out_dir),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_perr  (out_perr),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: beats collected in a queue, word built arithmetically.
    int            m_q[$];
    bit            m_sd, m_od, m_pend, m_valid, m_ovf, m_perr;
    logic [DW-1:0] m_raw, m_word, m_data;

    function automatic logic [DW-1:0] assemble(input int q[$], input bit sd);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < NB; k++)
            w = w | (DW'(q[k]) << (sd ? LN * (NB - 1 - k) : LN * k));
        return w;
    endfunction

    function automatic logic [DW-1:0] rev(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_sd = 0; m_od = 0; m_pend = 0; m_valid = 0; m_ovf = 0; m_perr = 0;
        m_raw = '0; m_word = '0; m_data = '0;
    endtask

    task automatic model_step();
        bit            hs, done, drop, pe;
        logic [DW-1:0] w;
        hs = m_valid && out_ready;
        done = 0; drop = 0; pe = 0; w = '0;
        if (flush) begin
            m_q.delete();
            m_pend = 0;
        end else if (in_valid) begin
            if (m_pend) begin
                done = 1; w = m_word; pe = (^m_raw) ^ serial_in[0]; m_pend = 0;
            end else begin
                if (m_q.size() == 0) begin m_sd = shift_dir; m_od = out_dir; end
                m_q.push_back(int'(serial_in));
                if (m_q.size() == NB) begin
                    m_raw  = assemble(m_q, m_sd);
                    m_word = m_od ? rev(m_raw) : m_raw;
                    m_q.delete();
                    if (PAR) m_pend = 1;
                    else begin done = 1; w = m_word; end
                end
            end
        end
        if (done) begin
            if (!m_valid || hs) begin m_data = w; m_valid = 1; m_perr = pe; end
            else drop = 1;
        end else if (hs) begin
            m_valid = 0;
        end
        m_ovf = drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    endtask

    task automatic check_all();
        check("valid", out_valid, m_valid);
        check("data", out_data, m_data);
        check("overflow", overflow, m_ovf);
        check("perr", out_perr, m_perr);
        check("busy", busy, (m_q.size() != 0) || m_pend);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [LN-1:0] d, input bit sd, input bit od,
                         input bit fl, input bit rdy, input bit clr);
        in_valid = v; serial_in = d; shift_dir = sd; out_dir = od;
        flush = fl; out_ready = rdy; ovf_clr = clr;
        cyc();
    endtask

    task automatic beats4(input bit sd, input bit od, input logic [DW-1:0] w,
                          input bit rdy_pre, input bit rdy_last);
        for (int k = 0; k < NB; k++)
            drive(1, w[DW-1-LN*k -: LN], sd, od, 0, (k == NB - 1 && !PAR) ? rdy_last : rdy_pre, 0);
    endtask

    // A full word; the parity build appends a correct even-parity beat.
    task automatic word4(input bit sd, input bit od, input logic [DW-1:0] w,
                         input bit rdy_pre, input bit rdy_last);
        beats4(sd, od, w, rdy_pre, rdy_last);
        if (PAR) drive(1, {1'b0, ^w}, sd, od, 0, rdy_last, 0);
    endtask

    task automatic idle(input bit rdy);
        drive(0, '0, 0, 0, 0, rdy, 0);
    endtask

    initial begin
        serial_in = '0; in_valid = 0; shift_dir = 0; out_dir = 0;
        flush = 0; out_ready = 0; ovf_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_perr", out_perr, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        arst_n = 1'b1;

        word4(1, 0, 8'hB1, 1, 1);
        check("shl_word", out_data, 8'hB1);
        check("shl_valid", out_valid, 1);
        idle(1);
        check("shl_consumed", out_valid, 0);
        word4(0, 0, 8'hB1, 1, 1);
        check("shr_word", out_data, 8'h4E);
        idle(1);
        word4(1, 1, 8'hB1, 1, 1);
        check("rev_word", out_data, 8'h8D);
        idle(1);

        word4(1, 0, 8'hB1, 0, 0);
        word4(0, 0, 8'hB1, 0, 0);
        check("ovf_hold", out_data, 8'hB1);
        check("ovf_set", overflow, 1);
        drive(0, '0, 0, 0, 0, 1, 1);
        check("ovf_clr", overflow, 0);
        check("ovf_drain", out_valid, 0);

        drive(1, 2'b01, 1, 0, 0, 1, 0);
        drive(1, 2'b10, 1, 0, 0, 1, 0);
        drive(1, 2'b11, 1, 0, 1, 1, 0);
        check("flush_busy", busy, 0);
        word4(1, 0, 8'h3C, 1, 1);
        check("flush_word", out_data, 8'h3C);
        idle(1);

        word4(1, 0, 8'h5A, 0, 0);
        word4(1, 0, 8'hC3, 0, 1);
        check("hs_word", out_data, 8'hC3);
        check("hs_valid", out_valid, 1);
        check("hs_ovf", overflow, 0);
        idle(1);

`ifdef SIPO_DESER_PARITY_EN
        beats4(1, 0, 8'hB1, 1, 1);
        drive(1, 2'b00, 1, 0, 0, 1, 0);
        check("par_ok", out_perr, 0);
        beats4(1, 0, 8'hB1, 1, 1);
        drive(1, 2'b01, 1, 0, 0, 1, 0);
        check("par_err", out_perr, 1);
        idle(1);
`endif

        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 9) < 7, LN'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);

        word4(1, 0, 8'hE7, 0, 0);
        drive(1, 2'b10, 1, 0, 0, 0, 0);
        #3;
        arst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_ovf", overflow, 0);
        check("arst_perr", out_perr, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        arst_n = 1'b1;
        word4(0, 1, 8'h96, 1, 1);
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
